channel_fifo: RTL and testbench

Parametrised successor to the single-skid handshake channel. It moves WIDTH-bit words from an upstream producer to a downstream consumer through DEPTH words of storage plus a registered output stage. All handshake outputs are registered, and the block sustains one word per clock in both directions. It sits between pipeline stages that need rate decoupling, or to break long combinational handshake paths.

---
 rtl/channel_pkg.sv | 24 ++
 rtl/channel_fifo_mem.sv | 27 ++
 rtl/channel_fifo.sv | 117 +++++++++++
 tb/tb_channel_fifo.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/channel_pkg.sv
// Shared helpers for channel_fifo: pointer/count/level widths and DEPTH legality.
package channel_pkg;

  // Read/write pointer width; pointers wrap naturally because DEPTH is a power of two.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Storage occupancy counter width, holding 0..DEPTH.
  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Level output width, holding 0..DEPTH+1 (storage plus output register).
  function automatic int unsigned level_width(input int unsigned depth);
    return $clog2(depth + 2);
  endfunction

  // DEPTH must be a power of two and at least 2.
  function automatic bit depth_legal(input int unsigned depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/channel_fifo_mem.sv
// DEPTH x WIDTH storage array: synchronous write, asynchronous read, no reset on contents.
module channel_fifo_mem
  import channel_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         wr_en,
  input  logic [ptr_width(DEPTH)-1:0]  wr_ptr,
  input  logic [WIDTH-1:0]             wr_dat,
  input  logic [ptr_width(DEPTH)-1:0]  rd_ptr,
  output logic [WIDTH-1:0]             rd_dat
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write the addressed entry on an accepted store.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr] <= wr_dat;
    end
  end

  assign rd_dat = mem_q[rd_ptr];

endmodule

// File: rtl/channel_fifo.sv
// channel_fifo: registered-handshake FIFO, DEPTH words of storage plus an output register.
// Optional feature: define CHANNEL_FIFO_BYPASS_EN to let a word go straight into the
// output register when storage is empty (latency 1 instead of 2).
module channel_fifo
  import channel_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [WIDTH-1:0]              in_dat,
  input  logic                          in_set,
  output logic                          in_get,
  output logic [WIDTH-1:0]              out_dat,
  output logic                          out_set,
  input  logic                          out_get,
  output logic [level_width(DEPTH)-1:0] level
);

  localparam int unsigned PtrW = ptr_width(DEPTH);
  localparam int unsigned CntW = count_width(DEPTH);
  localparam int unsigned LvlW = level_width(DEPTH);

  if (!depth_legal(DEPTH)) begin : g_depth_check
    $error("channel_fifo: DEPTH must be a power of two >= 2");
  end

  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             in_get_q, in_get_d;
  logic             out_set_q, out_set_d;
  logic [WIDTH-1:0] out_dat_q, out_dat_d;
  logic [LvlW-1:0]  level_q, level_d;
  logic [WIDTH-1:0] mem_rd_dat;
  logic             out_ready, wr_fire, rd_fire, mem_we;
`ifdef CHANNEL_FIFO_BYPASS_EN
  logic             byp_fire;
`endif

  channel_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk    (clk),
    .wr_en  (mem_we),
    .wr_ptr (wr_ptr_q),
    .wr_dat (in_dat),
    .rd_ptr (rd_ptr_q),
    .rd_dat (mem_rd_dat)
  );

  // Transfer decode and next-state for count, handshakes, output register and level.
  always_comb begin
    out_ready = !out_set_q || out_get;
    wr_fire   = in_set && in_get_q;
    rd_fire   = out_ready && (count_q != '0);
`ifdef CHANNEL_FIFO_BYPASS_EN
    byp_fire  = wr_fire && (count_q == '0) && out_ready;
    mem_we    = wr_fire && !byp_fire;
`else
    mem_we    = wr_fire;
`endif

    count_d = count_q;
    unique case ({mem_we, rd_fire})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    out_set_d = out_set_q;
    out_dat_d = out_dat_q;
    if (rd_fire) begin
      out_set_d = 1'b1;
      out_dat_d = mem_rd_dat;
`ifdef CHANNEL_FIFO_BYPASS_EN
    end else if (byp_fire) begin
      out_set_d = 1'b1;
      out_dat_d = in_dat;
`endif
    end else if (out_ready) begin
      // Drain: out_dat keeps its last value.
      out_set_d = 1'b0;
    end

    in_get_d = (count_d != CntW'(DEPTH));
    level_d  = LvlW'(count_d) + LvlW'(out_set_d);
  end

  // State update with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      in_get_q  <= 1'b0;
      out_set_q <= 1'b0;
      out_dat_q <= '0;
      level_q   <= '0;
    end else begin
      if (mem_we) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (rd_fire) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q   <= count_d;
      in_get_q  <= in_get_d;
      out_set_q <= out_set_d;
      out_dat_q <= out_dat_d;
      level_q   <= level_d;
    end
  end

  assign in_get  = in_get_q;
  assign out_set = out_set_q;
  assign out_dat = out_dat_q;
  assign level   = level_q;

endmodule

// File: tb/tb_channel_fifo.sv
// Scoreboard bench for channel_fifo: directed phases plus a random handshake phase.
module tb_channel_fifo;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW    = $clog2(DEPTH + 2);
`ifdef CHANNEL_FIFO_BYPASS_EN
  localparam int unsigned StreamLevel = 1;
`else
  localparam int unsigned StreamLevel = 2;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] in_dat;
  logic             in_set;
  logic             in_get;
  logic [WIDTH-1:0] out_dat;
  logic             out_set;
  logic             out_get;
  logic [LW-1:0]    level;

  int               n_checks = 0;
  int               n_fail   = 0;
  bit               mon_en   = 1'b0;
  bit               hold_v   = 1'b0;
  logic [WIDTH-1:0] hold_dat;
  logic [WIDTH-1:0] sb [$];

  channel_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_dat  (in_dat),
    .in_set  (in_set),
    .in_get  (in_get),
    .out_dat (out_dat),
    .out_set (out_set),
    .out_get (out_get),
    .level   (level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: on the falling edge, compare level against the scoreboard, then apply the
  // transfers that the next rising edge will perform.
  always @(negedge clk) begin
    if (mon_en) begin
      check("level_vs_scoreboard", 32'(level), 32'(sb.size()));
      if (!rst_n) begin
        sb.delete();
        hold_v = 1'b0;
      end else begin
        if (hold_v) begin
          check("out_dat_stable", 32'(out_dat), 32'(hold_dat));
          check("out_set_stable", 32'(out_set), 32'd1);
        end
        hold_v   = out_set && !out_get;
        hold_dat = out_dat;
        if (out_set && out_get) begin
          if (sb.size() == 0) begin
            check("pop_with_empty_scoreboard", 32'(out_dat), 32'hffff_ffff);
          end else begin
            check("out_dat_order", 32'(out_dat), 32'(sb.pop_front()));
          end
        end
        if (in_set && in_get) sb.push_back(in_dat);
      end
    end
  end

  initial begin
    rst_n   = 1'b0;
    in_set  = 1'b0;
    in_dat  = '0;
    out_get = 1'b0;
    step();
    step();
    check("reset_out_set", 32'(out_set), 32'd0);
    check("reset_in_get", 32'(in_get), 32'd0);
    check("reset_level", 32'(level), 32'd0);
    check("reset_out_dat", 32'(out_dat), 32'd0);
    mon_en = 1'b1;

    // Release with in_set high: not accepted on the first edge.
    rst_n  = 1'b1;
    in_set = 1'b1;
    in_dat = 8'hEE;
    step();
    check("release_in_get", 32'(in_get), 32'd1);
    check("release_no_accept", 32'(level), 32'd0);

    // Fill to capacity with out_get low.
    for (int k = 1; k <= 5; k++) begin
      in_dat = 8'(k);
      step();
    end
    in_set = 1'b0;
    check("full_in_get", 32'(in_get), 32'd0);
    check("full_level", 32'(level), 32'd5);
    check("full_out_dat", 32'(out_dat), 32'h01);
    check("full_out_set", 32'(out_set), 32'd1);

    // Drain from full.
    out_get = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      check("drain_out_dat", 32'(out_dat), 32'(k));
      step();
      if (k == 1) check("drain_in_get_rise", 32'(in_get), 32'd1);
    end
    check("drained_level", 32'(level), 32'd0);
    check("drained_out_set", 32'(out_set), 32'd0);

    // Stream 0x00..0xFF with both sides always ready.
    in_set = 1'b1;
    for (int i = 0; i < 256; i++) begin
      in_dat = 8'(i);
      step();
      check("stream_in_get", 32'(in_get), 32'd1);
      if (i >= 1) begin
        check("stream_out_set", 32'(out_set), 32'd1);
        check("stream_level", 32'(level), 32'(StreamLevel));
      end
    end
    in_set = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("stream_drained", 32'(level), 32'd0);

    // Single-word latency from an empty block.
    out_get = 1'b0;
    in_set  = 1'b1;
    in_dat  = 8'hA5;
    step();
    in_set = 1'b0;
`ifdef CHANNEL_FIFO_BYPASS_EN
    check("latency_out_set_n1", 32'(out_set), 32'd1);
    check("latency_out_dat_n1", 32'(out_dat), 32'hA5);
`else
    check("latency_out_set_n1", 32'(out_set), 32'd0);
    step();
    check("latency_out_set_n2", 32'(out_set), 32'd1);
    check("latency_out_dat_n2", 32'(out_dat), 32'hA5);
`endif
    out_get = 1'b1;
    step();
    out_get = 1'b0;
    check("latency_drained", 32'(level), 32'd0);

    // Random handshakes; the monitor tracks every transfer.
    for (int i = 0; i < 10000; i++) begin
      in_set  = 1'($urandom_range(0, 1));
      out_get = 1'($urandom_range(0, 1));
      in_dat  = 8'($urandom);
      step();
    end
    in_set  = 1'b0;
    out_get = 1'b1;
    for (int i = 0; i < DEPTH + 3; i++) step();
    check("random_drained", 32'(level), 32'd0);

    // Reset while three words are held.
    out_get = 1'b0;
    in_set  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_dat = 8'(8'h31 + k);
      step();
    end
    in_set = 1'b0;
    check("pre_reset_level", 32'(level), 32'd3);
    rst_n = 1'b0;
    step();
    check("midreset_out_set", 32'(out_set), 32'd0);
    check("midreset_in_get", 32'(in_get), 32'd0);
    check("midreset_level", 32'(level), 32'd0);
    rst_n = 1'b1;
    step();
    check("post_reset_in_get", 32'(in_get), 32'd1);
    in_set  = 1'b1;
    out_get = 1'b1;
    in_dat  = 8'h44;
    step();
    in_dat = 8'h55;
    step();
    in_set = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("post_reset_drained", 32'(level), 32'd0);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
